id_stage: RTL and testbench
===========================

// Module: id_stage
// PURPOSE
//   RV32I decode stage, between fetch and execute. Drives the register-file read selects
//   and decodes the immediate. Bypasses same-cycle writeback data around the synchronous
//   register file. Holds one decoded instruction in the ID/EX pipeline register, with a
//   valid/ready handshake on both sides, load-use stall and flush.
// PARAMETERS
//   XLEN        32   datapath width; only 32 is supported
//   RESET_PC    0    value of ex_pc while out is reset/empty
// PORTS
//   clk          in   1    clock
//   rst_n        in   1    reset, synchronous, active-low
//   flush        in   1    discard held and incoming instruction (branch/trap redirect)
//   if_valid     in   1    fetch offers instruction
//   if_ready     out  1    decode accepts instruction this cycle
//   if_instr     in   32   instruction word
//   if_pc        in   32   instruction address
//   rf_sel_1     out  5    register-file read select A = if_instr[19:15]
//   rf_sel_2     out  5    register-file read select B = if_instr[24:20]
//   rf_data_1    in   32   register-file read data A (combinational)
//   rf_data_2    in   32   register-file read data B
//   wb_en        in   1    writeback write enable (same signals as register-file write port)
//   wb_sel       in   5    writeback destination
//   wb_data      in   32   writeback data
//   hz_ld_valid  in   1    execute stage holds a load
//   hz_ld_rd     in   5    destination of that load
//   ex_valid     out  1    ID/EX register holds an instruction
//   ex_ready     in   1    execute consumes it this cycle
//   ex_pc        out  32   pc; ex_rs1_val/ex_rs2_val out 32 operand values
//   ex_imm       out  32   sign-extended immediate
//   ex_rd        out  5    destination; ex_rd_we out 1 (0 for STORE/BRANCH/rd==0/illegal)
//   ex_opcode    out  7    ex_funct3 out 3, ex_funct7b5 out 1 (instr[30])
//   ex_illegal   out  1    opcode not in RV32I base set
// BEHAVIOUR
//   - Reset (rst_n=0 at posedge): ex_valid=0; all ex_* data=0 except ex_pc=RESET_PC.
//     if_ready=0 during reset.
//   - Priority order: reset > flush > load > drain.
//   - Flush: next ex_valid=0. if_ready=0 that cycle; the fetched word is dropped.
//   - Use flags: uses_rs1 = opcode not in {LUI, AUIPC, JAL}.
//     uses_rs2 = opcode in {BRANCH, STORE, OP}.
//   - stall = hz_ld_valid & hz_ld_rd!=0 & ((uses_rs1 & rs1==hz_ld_rd) | (uses_rs2 & rs2==hz_ld_rd)).
//   - if_ready = rst_n & !flush & !stall & (!ex_valid | ex_ready).
//   - Load: if_valid & if_ready -> the register captures the decode; ex_valid=1 next cycle.
//     Latency is 1 cycle.
//   - Drain: ex_valid & ex_ready and no load -> ex_valid=0 (bubble).
//     A stall with ex_ready set also inserts a bubble.
//   - Hold: ex_valid & !ex_ready -> every ex_* output is stable.
//   - Operand bypass: val_n = (wb_en & wb_sel!=0 & wb_sel==rs_n) ? wb_data : rf_data_n.
//     rs_n==0 always gives 0.
//   - Immediate formats: I, S, B (bit0=0), U (low 12 bits=0), J (bit0=0), each sign-extended
//     from instr[31]. Other opcodes: imm=0.
//   - Illegal opcode: still loaded with ex_valid=1 and ex_illegal=1; ex_rd_we=0.
//   - Simultaneous load + drain: new instruction replaces old in the same edge; no bubble.
// CONFIGURATION
//   ID_WB_BYPASS_EN defined: writeback bypass as above.
//   ID_WB_BYPASS_EN undefined: no bypass mux.
//     stall additionally asserts when wb_en & wb_sel!=0 & wb_sel matches a used rs.
//     The register file has the value the next cycle.
// STRUCTURE
//   Package core_pkg: opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
//   OPC_LOAD, OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM), imm_fmt_t enum
//   {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}.
//   Sub-module imm_gen (combinational: instr -> fmt, imm). Stall/bypass/pipe register stay here.
// TESTING
//   1. Reset: hold rst_n=0 2 cycles with if_valid=1 -> ex_valid=0, if_ready=0, ex_pc=RESET_PC.
//   2. Issue addi x5,x1,-3 (0xFFD08293), x1=10 -> next cycle ex_valid=1, ex_imm=0xFFFFFFFD,
//      ex_rs1_val=10, ex_rd=5, ex_rd_we=1.
//   3. Bypass: issue add x3,x1,x2 while wb_en=1, wb_sel=1, wb_data=0x1234, rf_data_1=0
//      -> ex_rs1_val=0x1234. Build without the macro -> one stall cycle, then value from rf.
//   4. Load-use: hz_ld_valid=1, hz_ld_rd=2, decode sub x4,x2,x3 -> if_ready=0 and bubble
//      for 1 cycle; lui x2 with the same hazard does not stall.
//   5. Back-pressure + flush: ex_ready=0 for 3 cycles -> outputs stable, if_ready=0;
//      then flush=1 -> ex_valid=0 next cycle, the offered word is not captured.
//   6. Decode immediates: beq offset -4 -> ex_imm=0xFFFFFFFC; opcode 0x7F -> ex_illegal=1,
//      ex_rd_we=0; write to x0 -> ex_rd_we=0.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared RV32I decode definitions.
//   - OPC_* : 7-bit major opcodes of the RV32I base set
//   - imm_fmt_t : immediate format selected by the opcode
//   - id_ex_t : payload held in the ID/EX pipeline register
//   - opc_legal() : true when an opcode belongs to the RV32I base set
package core_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_I    = 3'd0,
      IMM_S    = 3'd1,
      IMM_B    = 3'd2,
      IMM_U    = 3'd3,
      IMM_J    = 3'd4,
      IMM_NONE = 3'd5
   } imm_fmt_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] rs1_val;
      logic [31:0] rs2_val;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rd_we;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic        funct7b5;
      logic        illegal;
   } id_ex_t;

   function automatic logic opc_legal(input logic [6:0] opc);
      logic ok;
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
         OPC_STORE, OPC_OPIMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: ok = 1'b1;
         default:                                            ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// imm_gen: combinational RV32I immediate decoder.
//   instr (in, 32)  instruction word
//   fmt   (out)     immediate format chosen from the opcode
//   imm   (out, 32) immediate, sign-extended from instr[31]; 0 when fmt is IMM_NONE
// JALR/LOAD/OP-IMM use the I format; FENCE and SYSTEM carry no immediate here.
module imm_gen
   import core_pkg::*;
(
   input  logic [31:0] instr,
   output imm_fmt_t    fmt,
   output logic [31:0] imm
);

   // Select the immediate format from the major opcode.
   always_comb begin
      fmt = IMM_NONE;
      case (instr[6:0])
         OPC_JALR, OPC_LOAD, OPC_OPIMM: fmt = IMM_I;
         OPC_STORE:                     fmt = IMM_S;
         OPC_BRANCH:                    fmt = IMM_B;
         OPC_LUI, OPC_AUIPC:            fmt = IMM_U;
         OPC_JAL:                       fmt = IMM_J;
         default:                       fmt = IMM_NONE;
      endcase
   end

   // Assemble and sign-extend the immediate for the chosen format.
   always_comb begin
      imm = 32'h0000_0000;
      case (fmt)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'h000};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'h0000_0000;
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with ID/EX pipeline register.
//   clk, rst_n (synchronous, active-low), flush
//   if_valid/if_ready/if_instr/if_pc     : fetch-side handshake
//   rf_sel_1/rf_sel_2, rf_data_1/2       : register-file read port (combinational data)
//   wb_en/wb_sel/wb_data                 : writeback port, same as the register-file write
//   hz_ld_valid/hz_ld_rd                 : load in execute, for load-use stalls
//   ex_valid/ex_ready and ex_*           : execute-side handshake and decoded payload
// Build option ID_WB_BYPASS_EN: when defined, writeback data is forwarded into the
// operands; when undefined, a writeback to a used source stalls one cycle instead,
// after which the register file returns the new value.
module id_stage
   import core_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic [4:0]      rf_sel_1,
   output logic [4:0]      rf_sel_2,
   input  logic [XLEN-1:0] rf_data_1,
   input  logic [XLEN-1:0] rf_data_2,
   input  logic            wb_en,
   input  logic [4:0]      wb_sel,
   input  logic [XLEN-1:0] wb_data,
   input  logic            hz_ld_valid,
   input  logic [4:0]      hz_ld_rd,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_rs1_val,
   output logic [XLEN-1:0] ex_rs2_val,
   output logic [XLEN-1:0] ex_imm,
   output logic [4:0]      ex_rd,
   output logic            ex_rd_we,
   output logic [6:0]      ex_opcode,
   output logic [2:0]      ex_funct3,
   output logic            ex_funct7b5,
   output logic            ex_illegal
);

   logic [6:0]  opcode_s;
   logic [4:0]  rs1_s;
   logic [4:0]  rs2_s;
   logic [4:0]  rd_s;
   imm_fmt_t    fmt_s;
   logic [31:0] imm_s;
   logic        uses_rs1_s;
   logic        uses_rs2_s;
   logic        ld_hit_s;
   logic        wb_hit1_s;
   logic        wb_hit2_s;
   logic        stall_s;
   logic        if_ready_s;
   logic        load_s;
   logic [31:0] rs1_val_s;
   logic [31:0] rs2_val_s;
   id_ex_t      dec_s;
   id_ex_t      ex_r;
   logic        ex_valid_r;

   assign opcode_s = if_instr[6:0];
   assign rd_s     = if_instr[11:7];
   assign rs1_s    = if_instr[19:15];
   assign rs2_s    = if_instr[24:20];

   imm_gen u_imm_gen (
      .instr (if_instr),
      .fmt   (fmt_s),
      .imm   (imm_s)
   );

   // Source usage, hazard detection and the fetch-side ready.
   // U-format (LUI/AUIPC) and J-format (JAL) are exactly the opcodes without rs1;
   // S/B formats plus register-register OP are exactly those reading rs2.
   always_comb begin
      uses_rs1_s = (fmt_s != IMM_U) && (fmt_s != IMM_J);
      uses_rs2_s = (fmt_s == IMM_S) || (fmt_s == IMM_B) || (opcode_s == OPC_OP);
      ld_hit_s   = hz_ld_valid && (hz_ld_rd != 5'd0) &&
                   ((uses_rs1_s && (rs1_s == hz_ld_rd)) || (uses_rs2_s && (rs2_s == hz_ld_rd)));
      wb_hit1_s  = wb_en && (wb_sel != 5'd0) && (wb_sel == rs1_s);
      wb_hit2_s  = wb_en && (wb_sel != 5'd0) && (wb_sel == rs2_s);
`ifdef ID_WB_BYPASS_EN
      stall_s    = ld_hit_s;
`else
      stall_s    = ld_hit_s || (uses_rs1_s && wb_hit1_s) || (uses_rs2_s && wb_hit2_s);
`endif
      if_ready_s = rst_n && !flush && !stall_s && (!ex_valid_r || ex_ready);
      load_s     = if_valid && if_ready_s;
   end

   // Operand selection; x0 always reads as zero regardless of the register file.
   always_comb begin
      rs1_val_s = 32'h0000_0000;
      rs2_val_s = 32'h0000_0000;
`ifdef ID_WB_BYPASS_EN
      if (rs1_s == 5'd0) begin
         rs1_val_s = 32'h0000_0000;
      end else if (wb_hit1_s) begin
         rs1_val_s = wb_data;
      end else begin
         rs1_val_s = rf_data_1;
      end
      if (rs2_s == 5'd0) begin
         rs2_val_s = 32'h0000_0000;
      end else if (wb_hit2_s) begin
         rs2_val_s = wb_data;
      end else begin
         rs2_val_s = rf_data_2;
      end
`else
      if (rs1_s == 5'd0) begin
         rs1_val_s = 32'h0000_0000;
      end else begin
         rs1_val_s = rf_data_1;
      end
      if (rs2_s == 5'd0) begin
         rs2_val_s = 32'h0000_0000;
      end else begin
         rs2_val_s = rf_data_2;
      end
`endif
   end

`ifndef ID_WB_BYPASS_EN
   // Without forwarding the writeback data is only seen through the register file.
   logic unused_wb_data_s;
   assign unused_wb_data_s = ^wb_data;
`endif

   // Build the payload that a load would capture.
   always_comb begin
      dec_s          = '0;
      dec_s.pc       = if_pc;
      dec_s.rs1_val  = rs1_val_s;
      dec_s.rs2_val  = rs2_val_s;
      dec_s.imm      = imm_s;
      dec_s.rd       = rd_s;
      dec_s.opcode   = opcode_s;
      dec_s.funct3   = if_instr[14:12];
      dec_s.funct7b5 = if_instr[30];
      dec_s.illegal  = !opc_legal(opcode_s);
      if (dec_s.illegal || (opcode_s == OPC_STORE) || (opcode_s == OPC_BRANCH) || (rd_s == 5'd0)) begin
         dec_s.rd_we = 1'b0;
      end else begin
         dec_s.rd_we = 1'b1;
      end
   end

   // ID/EX register: reset > flush > load > drain; otherwise hold.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_valid_r <= 1'b0;
         ex_r       <= '0;
         ex_r.pc    <= RESET_PC;
      end else if (flush) begin
         ex_valid_r <= 1'b0;
      end else if (load_s) begin
         ex_valid_r <= 1'b1;
         ex_r       <= dec_s;
      end else if (ex_ready) begin
         // Plain drain, or a stalled decode leaving a bubble behind.
         ex_valid_r <= 1'b0;
      end
   end

   assign if_ready    = if_ready_s;
   assign rf_sel_1    = rs1_s;
   assign rf_sel_2    = rs2_s;
   assign ex_valid    = ex_valid_r;
   assign ex_pc       = ex_r.pc;
   assign ex_rs1_val  = ex_r.rs1_val;
   assign ex_rs2_val  = ex_r.rs2_val;
   assign ex_imm      = ex_r.imm;
   assign ex_rd       = ex_r.rd;
   assign ex_rd_we    = ex_r.rd_we;
   assign ex_opcode   = ex_r.opcode;
   assign ex_funct3   = ex_r.funct3;
   assign ex_funct7b5 = ex_r.funct7b5;
   assign ex_illegal  = ex_r.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the decode stage. The model follows the build option
// ID_WB_BYPASS_EN the same way the design does.
module tb_id_stage;

   localparam logic [31:0] RESET_PC = 32'h0000_1000;

   localparam logic [6:0] T_LUI    = 7'h37;
   localparam logic [6:0] T_AUIPC  = 7'h17;
   localparam logic [6:0] T_JAL    = 7'h6F;
   localparam logic [6:0] T_JALR   = 7'h67;
   localparam logic [6:0] T_BRANCH = 7'h63;
   localparam logic [6:0] T_LOAD   = 7'h03;
   localparam logic [6:0] T_STORE  = 7'h23;
   localparam logic [6:0] T_OPIMM  = 7'h13;
   localparam logic [6:0] T_OP     = 7'h33;
   localparam logic [6:0] T_FENCE  = 7'h0F;
   localparam logic [6:0] T_SYSTEM = 7'h73;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [4:0]  rf_sel_1;
   logic [4:0]  rf_sel_2;
   logic [31:0] rf_data_1;
   logic [31:0] rf_data_2;
   logic        wb_en;
   logic [4:0]  wb_sel;
   logic [31:0] wb_data;
   logic        hz_ld_valid;
   logic [4:0]  hz_ld_rd;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_pc;
   logic [31:0] ex_rs1_val;
   logic [31:0] ex_rs2_val;
   logic [31:0] ex_imm;
   logic [4:0]  ex_rd;
   logic        ex_rd_we;
   logic [6:0]  ex_opcode;
   logic [2:0]  ex_funct3;
   logic        ex_funct7b5;
   logic        ex_illegal;

   id_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .rf_sel_1(rf_sel_1), .rf_sel_2(rf_sel_2), .rf_data_1(rf_data_1), .rf_data_2(rf_data_2),
      .wb_en(wb_en), .wb_sel(wb_sel), .wb_data(wb_data),
      .hz_ld_valid(hz_ld_valid), .hz_ld_rd(hz_ld_rd),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc),
      .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_imm(ex_imm),
      .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
      .ex_funct7b5(ex_funct7b5), .ex_illegal(ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file seen by the stage: synchronous write, combinational read.
   // x0 deliberately holds a nonzero value so that the decode must force it to zero.
   logic [31:0] regs [32];
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'(i) * 32'h0001_0101 + 32'h0000_0007;
      end else if (wb_en && wb_sel != 5'd0) begin
         regs[wb_sel] <= wb_data;
      end
   end
   assign rf_data_1 = regs[rf_sel_1];
   assign rf_data_2 = regs[rf_sel_2];

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] v1;
      logic [31:0] v2;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic        rd_we;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7;
      logic        ill;
   } exp_t;

   exp_t m;
   bit   m_valid;
   bit   obs_rdy;
   bit   last_acc;
   int   n_vec;
   int   n_err;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_legal(input logic [6:0] op);
      return op inside {T_LUI, T_AUIPC, T_JAL, T_JALR, T_BRANCH, T_LOAD,
                        T_STORE, T_OPIMM, T_OP, T_FENCE, T_SYSTEM};
   endfunction

   // Immediate value computed arithmetically from the field weights.
   function automatic logic [31:0] ref_imm(input logic [31:0] w);
      logic [31:0] s;
      s = 32'(w[31]);
      if (w[6:0] inside {T_JALR, T_LOAD, T_OPIMM})
         return 32'(w[30:20]) - s * 32'd2048;
      else if (w[6:0] == T_STORE)
         return 32'(w[30:25]) * 32'd32 + 32'(w[11:7]) - s * 32'd2048;
      else if (w[6:0] == T_BRANCH)
         return 32'(w[7]) * 32'd2048 + 32'(w[30:25]) * 32'd32 + 32'(w[11:8]) * 32'd2 - s * 32'd4096;
      else if (w[6:0] inside {T_LUI, T_AUIPC})
         return 32'(w[31:12]) * 32'd4096;
      else if (w[6:0] == T_JAL)
         return 32'(w[19:12]) * 32'd4096 + 32'(w[20]) * 32'd2048 + 32'(w[30:21]) * 32'd2 - s * 32'h0010_0000;
      else
         return 32'h0;
   endfunction

   function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
      bit u1, u2;
      u1 = !(w[6:0] inside {T_LUI, T_AUIPC, T_JAL});
      u2 = w[6:0] inside {T_BRANCH, T_STORE, T_OP};
      return (u1 && w[19:15] == r) || (u2 && w[24:20] == r);
   endfunction

   function automatic bit ref_stall(input logic [31:0] w);
      bit st;
      st = hz_ld_valid && hz_ld_rd != 5'd0 && reads_reg(w, hz_ld_rd);
`ifndef ID_WB_BYPASS_EN
      st = st || (wb_en && wb_sel != 5'd0 && reads_reg(w, wb_sel));
`endif
      return st;
   endfunction

   function automatic logic [31:0] ref_operand(input logic [4:0] r);
      if (r == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
      if (wb_en && wb_sel == r) return wb_data;
`endif
      return regs[r];
   endfunction

   // One clock: check the combinational outputs, step the model, check the register.
   task automatic tick();
      bit   exp_rdy, nv, was_rst;
      exp_t nm;
      #1;
      exp_rdy = rst_n && !flush && !ref_stall(if_instr) && (!m_valid || ex_ready);
      obs_rdy = if_ready;
      check("if_ready", 32'(if_ready), 32'(exp_rdy));
      check("rf_sel_1", 32'(rf_sel_1), 32'(if_instr[19:15]));
      check("rf_sel_2", 32'(rf_sel_2), 32'(if_instr[24:20]));
      nv = m_valid;
      nm = m;
      was_rst = !rst_n;
      last_acc = 1'b0;
      if (!rst_n) begin
         nv = 1'b0;
         nm = '0;
         nm.pc = RESET_PC;
      end else if (flush) begin
         nv = 1'b0;
      end else if (if_valid && exp_rdy) begin
         last_acc = 1'b1;
         nv = 1'b1;
         nm.pc  = if_pc;
         nm.v1  = ref_operand(if_instr[19:15]);
         nm.v2  = ref_operand(if_instr[24:20]);
         nm.imm = ref_imm(if_instr);
         nm.rd  = if_instr[11:7];
         nm.opc = if_instr[6:0];
         nm.f3  = if_instr[14:12];
         nm.f7  = if_instr[30];
         nm.ill = !is_legal(if_instr[6:0]);
         nm.rd_we = !nm.ill && !(if_instr[6:0] inside {T_STORE, T_BRANCH}) && if_instr[11:7] != 5'd0;
      end else if (ex_ready) begin
         nv = 1'b0;
      end
      @(posedge clk);
      #1;
      m_valid = nv;
      m = nm;
      check("ex_valid", 32'(ex_valid), 32'(m_valid));
      if (m_valid || was_rst) begin
         check("ex_pc", ex_pc, m.pc);
         check("ex_rs1_val", ex_rs1_val, m.v1);
         check("ex_rs2_val", ex_rs2_val, m.v2);
         check("ex_imm", ex_imm, m.imm);
         check("ex_rd", 32'(ex_rd), 32'(m.rd));
         check("ex_rd_we", 32'(ex_rd_we), 32'(m.rd_we));
         check("ex_opcode", 32'(ex_opcode), 32'(m.opc));
         check("ex_funct3", 32'(ex_funct3), 32'(m.f3));
         check("ex_funct7b5", 32'(ex_funct7b5), 32'(m.f7));
         check("ex_illegal", 32'(ex_illegal), 32'(m.ill));
      end
   endtask

   task automatic idle();
      if_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; hz_ld_valid = 1'b0; ex_ready = 1'b1;
   endtask

   task automatic issue(input logic [31:0] w, input logic [31:0] pc);
      if_instr = w; if_pc = pc; if_valid = 1'b1;
      tick();
      if_valid = 1'b0;
   endtask

   task automatic rf_write(input logic [4:0] r, input logic [31:0] d);
      wb_en = 1'b1; wb_sel = r; wb_data = d;
      tick();
      wb_en = 1'b0;
   endtask

   initial begin
      int          cyc;
      int          exp_cyc;
      logic [6:0]  ops [14];
      logic [31:0] w;
      n_vec = 0; n_err = 0; m_valid = 1'b0; m = '0;
      rst_n = 1'b0; flush = 1'b0; if_valid = 1'b1; if_instr = 32'hFFD0_8293; if_pc = 32'h0;
      wb_en = 1'b0; wb_sel = 5'd0; wb_data = 32'h0; hz_ld_valid = 1'b0; hz_ld_rd = 5'd0;
      ex_ready = 1'b0;

      // Reset held for two cycles with fetch offering a word.
      tick(); tick();
      check("rst_ex_valid", 32'(ex_valid), 32'h0);
      check("rst_ex_pc", ex_pc, RESET_PC);
      check("rst_if_ready", 32'(obs_rdy), 32'h0);
      rst_n = 1'b1; idle(); tick();

      // addi x5,x1,-3 with x1 = 10.
      rf_write(5'd1, 32'd10);
      issue(32'hFFD0_8293, 32'h0000_0100);
      check("addi_valid", 32'(ex_valid), 32'h1);
      check("addi_imm", ex_imm, 32'hFFFF_FFFD);
      check("addi_rs1", ex_rs1_val, 32'd10);
      check("addi_rd", 32'(ex_rd), 32'd5);
      check("addi_rd_we", 32'(ex_rd_we), 32'h1);

      // add x3,x1,x2 while x1 is being written back with 0x1234 (x1 currently 0).
      rf_write(5'd1, 32'h0);
      if_instr = 32'h0020_81B3; if_pc = 32'h0000_0104; if_valid = 1'b1;
      wb_en = 1'b1; wb_sel = 5'd1; wb_data = 32'h0000_1234;
      cyc = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         wb_en = 1'b0;
         cyc++;
         if (last_acc) break;
      end
      if_valid = 1'b0;
`ifdef ID_WB_BYPASS_EN
      exp_cyc = 1;
`else
      exp_cyc = 2;
`endif
      check("byp_cycles", 32'(cyc), 32'(exp_cyc));
      check("byp_rs1", ex_rs1_val, 32'h0000_1234);

      // Load-use hazard on x2: sub stalls and leaves a bubble, lui x2 does not.
      hz_ld_valid = 1'b1; hz_ld_rd = 5'd2;
      issue(32'h4031_0233, 32'h0000_0108);
      check("lduse_rdy", 32'(obs_rdy), 32'h0);
      check("lduse_bubble", 32'(ex_valid), 32'h0);
      issue(32'h1231_0137, 32'h0000_010C);
      check("lui_rdy", 32'(obs_rdy), 32'h1);
      check("lui_valid", 32'(ex_valid), 32'h1);
      hz_ld_valid = 1'b0;

      // Back-pressure for three cycles, then flush drops the offered word.
      ex_ready = 1'b0; if_valid = 1'b1; if_instr = 32'h0010_8313; if_pc = 32'h0000_0110;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("bp_rdy", 32'(obs_rdy), 32'h0);
         check("bp_rd_hold", 32'(ex_rd), 32'd2);
      end
      flush = 1'b1; tick();
      check("flush_valid", 32'(ex_valid), 32'h0);
      flush = 1'b0; if_valid = 1'b0; ex_ready = 1'b1; tick();
      check("flush_dropped", 32'(ex_valid), 32'h0);

      // Immediate/legality corner cases.
      issue(32'hFE00_0EE3, 32'h0000_0200);
      check("beq_imm", ex_imm, 32'hFFFF_FFFC);
      check("beq_rd_we", 32'(ex_rd_we), 32'h0);
      issue(32'h0000_017F, 32'h0000_0204);
      check("ill_valid", 32'(ex_valid), 32'h1);
      check("ill_flag", 32'(ex_illegal), 32'h1);
      check("ill_rd_we", 32'(ex_rd_we), 32'h0);
      issue(32'h0000_0013, 32'h0000_0208);
      check("x0_rd_we", 32'(ex_rd_we), 32'h0);

      // Randomized traffic.
      ops = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BRANCH, T_LOAD, T_STORE,
              T_OPIMM, T_OP, T_FENCE, T_SYSTEM, 7'h7F, 7'h00, 7'h2B};
      for (int c = 0; c < 3000; c++) begin
         w = $urandom;
         w[6:0]   = ops[$urandom_range(0, 13)];
         w[11:7]  = 5'($urandom_range(0, 7));
         w[19:15] = 5'($urandom_range(0, 3));
         w[24:20] = 5'($urandom_range(0, 3));
         if_instr    = w;
         if_pc       = $urandom;
         if_valid    = ($urandom_range(0, 9) < 8);
         ex_ready    = ($urandom_range(0, 9) < 7);
         flush       = ($urandom_range(0, 19) == 0);
         rst_n       = ($urandom_range(0, 99) != 0);
         hz_ld_valid = ($urandom_range(0, 3) == 0);
         hz_ld_rd    = 5'($urandom_range(0, 3));
         wb_en       = ($urandom_range(0, 2) == 0);
         wb_sel      = 5'($urandom_range(0, 3));
         wb_data     = $urandom;
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
